// File: rtl/mux_stream_rr_pkg.sv
// rtl/mux_stream_rr_pkg.sv - shared constants and helpers for the streaming mux
// Purpose: mode encodings and a channel-slice extraction helper.
// Ports: none (package).
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Widest packed channel bus the helper accepts; callers zero-extend into it.
  localparam int MAX_BUS = 1024;

  // Returns channel k of a packed bus with w bits per channel, right-aligned.
  // The caller truncates the result to its channel width.
  function automatic logic [MAX_BUS-1:0] chan_slice(input logic [MAX_BUS-1:0] bus,
                                                     input int unsigned k,
                                                     input int unsigned w);
    return bus >> (k * w);
  endfunction

endpackage

// File: rtl/mux_stream_rr_if.sv
// rtl/mux_stream_rr_if.sv - handshake bundle between producers, the mux and the consumer
// Purpose: groups control, N input streams and the single output stream.
// Ports: mode, sel, in_data/in_valid/in_ready, out_data/out_ch/out_valid/out_ready.
//   slave  : mux side (consumes inputs, drives in_ready and the output stream)
//   master : environment side (drives inputs and out_ready)
interface mux_stream_rr_if #(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int SELW  = $clog2(NCH)
);

  logic                  mode;
  logic [SELW-1:0]       sel;
  logic [NCH*WIDTH-1:0]  in_data;
  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SELW-1:0]       out_ch;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_stream_rr_arbiter.sv
// rtl/mux_stream_rr_arbiter.sv - combinational round-robin arbiter
// Purpose: picks the first set req bit searching upward from ptr, wrapping NCH-1 -> 0.
// Ports: req[NCH] requests, ptr[SELW] search start,
//        grant_vld any request found, grant_id[SELW] chosen channel.
module rr_arbiter #(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_vld,
  output logic [SELW-1:0] grant_id
);

  // Scan offsets from farthest to nearest so the nearest request wins last.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NCH;
      if (req[idx]) begin
        grant_vld = 1'b1;
        grant_id  = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_stream_rr.sv
// rtl/mux_stream_rr.sv - N-channel streaming mux with round-robin / fixed select
// Purpose: arbitrates NCH valid/ready producers into one registered output stage.
// Ports: clk, rst_n (async, active-low), bus (mux_stream_rr_if.slave):
//        mode/sel control, in_data/in_valid/in_ready inputs,
//        out_data/out_ch/out_valid/out_ready registered output.
module mux_stream_rr
  import mux_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_stream_rr_if.slave bus
);

  logic [SELW-1:0] ptr;
  logic [NCH-1:0]  req_m;
  logic            grant_vld;
  logic [SELW-1:0] grant_id;
  logic            load_en;
  logic            xfer;
  logic [WIDTH-1:0] next_data;
  logic [SELW-1:0] ptr_next;

  assign load_en = !bus.out_valid || bus.out_ready;

  // Fixed select reuses the arbiter by leaving only the selected request visible;
  // an out-of-range sel masks everything so nothing is granted.
  always_comb begin
    req_m = '0;
    if (bus.mode == MODE_FIXED) begin
      if (32'(bus.sel) < NCH) req_m[bus.sel] = bus.in_valid[bus.sel];
    end else begin
      req_m = bus.in_valid;
    end
  end

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req       (req_m),
    .ptr       (ptr),
    .grant_vld (grant_vld),
    .grant_id  (grant_id)
  );

  // Held low during reset so no producer sees an acceptance that gets dropped.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load_en && grant_vld) bus.in_ready[grant_id] = 1'b1;
  end

  // A grant only exists for a valid request, so grant plus load is a transfer.
  assign xfer      = load_en && grant_vld;
  assign next_data = WIDTH'(chan_slice(MAX_BUS'(bus.in_data), 32'(grant_id), WIDTH));
  assign ptr_next  = (grant_id == SELW'(NCH - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr           <= '0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      bus.out_valid <= 1'b0;
    end else if (xfer) begin
      bus.out_data  <= next_data;
      bus.out_ch    <= grant_id;
      bus.out_valid <= 1'b1;
      if (bus.mode == MODE_RR) ptr <= ptr_next;
    end else if (bus.out_valid && bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream_rr.sv
// tb/tb_mux_stream_rr.sv - directed self-checking bench for mux_stream_rr
module tb_mux_stream_rr;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mux_stream_rr_if #(.WIDTH(4), .NCH(4)) if4 ();
  mux_stream_rr_if #(.WIDTH(4), .NCH(3)) if3 ();

  mux_stream_rr #(.WIDTH(4), .NCH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  mux_stream_rr #(.WIDTH(4), .NCH(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    if4.mode = 1'b0; if4.sel = 2'd0; if4.in_data = 16'h3210;
    if4.in_valid = 4'b1111; if4.out_ready = 1'b1;
    if3.mode = 1'b0; if3.sel = 2'd0; if3.in_data = 12'h210;
    if3.in_valid = 3'b000; if3.out_ready = 1'b1;

    // reset state
    step(); step();
    check("rst_valid", 32'(if4.out_valid), 32'd0);
    check("rst_data",  32'(if4.out_data),  32'd0);
    check("rst_ch",    32'(if4.out_ch),    32'd0);
    check("rst_ready", 32'(if4.in_ready),  32'd0);

    // round-robin, all valid
    rst_n = 1'b1;
    #1 check("rr_first_ready", 32'(if4.in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      step();
      check("rr_ch",    32'(if4.out_ch),    32'(i % 4));
      check("rr_data",  32'(if4.out_data),  32'(i % 4));
      check("rr_valid", 32'(if4.out_valid), 32'd1);
      check("rr_ready", 32'(if4.in_ready),  32'(1 << ((i + 1) % 4)));
    end

    // asynchronous reset while holding ch3
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(if4.out_valid), 32'd0);
    check("arst_data",  32'(if4.out_data),  32'd0);
    check("arst_ch",    32'(if4.out_ch),    32'd0);
    step();
    rst_n = 1'b1;
    #1 check("post_rst_ready", 32'(if4.in_ready), 32'b0001);
    step();
    check("bp_first_ch", 32'(if4.out_ch), 32'd0);

    // backpressure
    if4.out_ready = 1'b0;
    #1 check("bp_ready0", 32'(if4.in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_data",  32'(if4.out_data),  32'd0);
      check("bp_ch",    32'(if4.out_ch),    32'd0);
      check("bp_valid", 32'(if4.out_valid), 32'd1);
      check("bp_ready", 32'(if4.in_ready),  32'd0);
    end
    if4.out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(if4.in_ready), 32'b0010);
    step();
    check("bp_next_ch",    32'(if4.out_ch),    32'd1);
    check("bp_next_data",  32'(if4.out_data),  32'd1);
    check("bp_next_valid", 32'(if4.out_valid), 32'd1);

    // sparse requests from ptr=0
    rst_n = 1'b0;
    step();
    if4.in_valid = 4'b1010;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("sparse_ch", 32'(if4.out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    step();
    check("sparse_ch1", 32'(if4.out_ch), 32'd1);
    if4.in_valid = 4'b0010;
    step();
    check("skip_ch",    32'(if4.out_ch),    32'd1);
    check("skip_valid", 32'(if4.out_valid), 32'd1);

    // fixed select, ptr left at 2
    if4.mode = 1'b1;
    if4.in_valid = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      if4.sel = 2'(s);
      #1 check("fix_ready_sel", 32'(if4.in_ready), 32'(1 << s));
      for (int k = 0; k < 5; k++) begin
        step();
        check("fix_ch",    32'(if4.out_ch),   32'(s));
        check("fix_data",  32'(if4.out_data), 32'(s));
        check("fix_ready", 32'(if4.in_ready), 32'(1 << s));
      end
    end
    if4.mode = 1'b0;
    #1 check("ptr_kept", 32'(if4.in_ready), 32'b0100);

    // drain without reload
    if4.in_valid = 4'b0000;
    #1 check("drain_ready", 32'(if4.in_ready), 32'd0);
    step();
    check("drain_valid", 32'(if4.out_valid), 32'd0);
    check("drain_data",  32'(if4.out_data),  32'd3);
    check("drain_ch",    32'(if4.out_ch),    32'd3);

    // NCH=3, out-of-range select
    if3.in_valid = 3'b001;
    #1 check("n3_ready", 32'(if3.in_ready), 32'b001);
    step();
    check("n3_valid", 32'(if3.out_valid), 32'd1);
    check("n3_ch",    32'(if3.out_ch),    32'd0);
    if3.mode = 1'b1;
    if3.sel = 2'd3;
    if3.in_valid = 3'b111;
    #1 check("badsel_ready", 32'(if3.in_ready), 32'd0);
    step();
    check("badsel_drain", 32'(if3.out_valid), 32'd0);
    step();
    check("badsel_idle",   32'(if3.out_valid), 32'd0);
    check("badsel_ready2", 32'(if3.in_ready),  32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
